// File: rtl/vga_ctrl_pkg.sv
// Shared VGA timing defaults (640x480@60) and the line-request FSM state encoding.
package vga_ctrl_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    REQ_IDLE = 2'd0,
    REQ_PEND = 2'd1,
    REQ_DONE = 2'd2,
    REQ_MISS = 2'd3
  } req_state_t;

endpackage

// File: rtl/vga_line_req_fsm.sv
// Line-fetch request FSM with sticky underrun flag.
// Optional VGA_UNDERRUN_BLANK_EN: blank the whole line entered after a missed fetch.
module vga_line_req_fsm
  import vga_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_start,
  input  logic       i_line_wrap,
  input  logic [9:0] i_next_line,
  input  logic       i_line_ack,
  input  logic       i_clr_underrun,
  output logic       o_line_req,
  output logic [9:0] o_line_num,
  output logic       o_underrun,
  output logic       o_blank_nxt,
  output logic [1:0] o_state
);

  // Handshake: line_req (valid) stays high with line_num stable until line_ack
  // (ready) is sampled high on a clock edge; acks outside PEND are ignored, and an
  // ack on the wrap edge wins over the miss.
  req_state_t r_state;
  logic [9:0] r_line_num;
  logic       r_underrun;
  logic       w_miss;

  assign w_miss = (r_state == REQ_PEND) && i_line_wrap && !i_line_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= REQ_IDLE;
      r_line_num <= 10'd0;
      r_underrun <= 1'b0;
    end else begin
      case (r_state)
        REQ_PEND: begin
          if (i_line_ack)       r_state <= REQ_DONE;
          else if (i_line_wrap) r_state <= REQ_MISS;
        end
        default: begin
          if (i_req_start) begin
            r_state    <= REQ_PEND;
            r_line_num <= i_next_line;
          end
        end
      endcase
      if (w_miss)              r_underrun <= 1'b1;
      else if (i_clr_underrun) r_underrun <= 1'b0;
    end
  end

`ifdef VGA_UNDERRUN_BLANK_EN
  logic r_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_blank <= 1'b0;
    else if (i_line_wrap) r_blank <= w_miss;
  end

  // Value the blank flag takes for the line being entered on this edge.
  assign o_blank_nxt = i_line_wrap ? w_miss : r_blank;
`else
  assign o_blank_nxt = 1'b0;
`endif

  assign o_line_req = (r_state == REQ_PEND);
  assign o_line_num = r_line_num;
  assign o_underrun = r_underrun;
  assign o_state    = r_state;

endmodule

// File: rtl/vga_line_scheduler.sv
// VGA beam counters, sync decode and line-fetch scheduling for a pixel generator.
// Optional VGA_UNDERRUN_BLANK_EN (see vga_line_req_fsm) blanks lines whose fetch missed.
module vga_line_scheduler
  import vga_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       frame_start,
  output logic       line_req,
  output logic [9:0] line_num,
  input  logic       line_ack,
  output logic       underrun,
  input  logic       clr_underrun,
  output logic [1:0] o_dbg_state
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] L_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] L_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] L_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] L_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_hpos, r_vpos;
  logic       r_hsync, r_vsync, r_display, r_frame_start;
  logic       w_h_last, w_v_last, w_line_wrap, w_req_start, w_blank_nxt;
  logic [9:0] w_hpos_nxt, w_vpos_nxt, w_next_line;

  assign w_h_last    = (r_hpos == L_H_LAST);
  assign w_v_last    = (r_vpos == L_V_LAST);
  assign w_hpos_nxt  = w_h_last ? 10'd0 : r_hpos + 10'd1;
  assign w_next_line = w_v_last ? 10'd0 : r_vpos + 10'd1;
  assign w_vpos_nxt  = w_h_last ? w_next_line : r_vpos;
  assign w_line_wrap = ena && w_h_last;
  // Reset parks the beam at (H_ACTIVE, V_TOTAL-1) so the first advance requests line 0.
  assign w_req_start = ena && (r_hpos == L_H_ACT) && (w_next_line < L_V_ACT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hpos        <= L_H_ACT;
      r_vpos        <= L_V_LAST;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_display     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_line_wrap && w_v_last;
      if (ena) begin
        r_hpos    <= w_hpos_nxt;
        r_vpos    <= w_vpos_nxt;
        r_hsync   <= !((w_hpos_nxt >= L_HS_BEG) && (w_hpos_nxt < L_HS_END));
        r_vsync   <= !((w_vpos_nxt >= L_VS_BEG) && (w_vpos_nxt < L_VS_END));
        r_display <= (w_hpos_nxt < L_H_ACT) && (w_vpos_nxt < L_V_ACT) && !w_blank_nxt;
      end
    end
  end

  vga_line_req_fsm u_req_fsm (
    .clk            (clk),
    .rst            (rst),
    .i_req_start    (w_req_start),
    .i_line_wrap    (w_line_wrap),
    .i_next_line    (w_next_line),
    .i_line_ack     (line_ack),
    .i_clr_underrun (clr_underrun),
    .o_line_req     (line_req),
    .o_line_num     (line_num),
    .o_underrun     (underrun),
    .o_blank_nxt    (w_blank_nxt),
    .o_state        (o_dbg_state)
  );

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_display;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_line_scheduler.sv
// Bench for vga_line_scheduler on a reduced timing set; pixel-index reference model.
module tb_vga_line_scheduler;
  import vga_ctrl_pkg::*;

  localparam int TH_ACT = 64, TH_FP = 8, TH_SYNC = 12, TH_BP = 6;
  localparam int TV_ACT = 48, TV_FP = 3, TV_SYNC = 2, TV_BP = 4;
  localparam int TH_TOT = TH_ACT + TH_FP + TH_SYNC + TH_BP;
  localparam int TV_TOT = TV_ACT + TV_FP + TV_SYNC + TV_BP;
  localparam int FRAME  = TH_TOT * TV_TOT;

  logic       clk = 1'b0, rst = 1'b1, ena = 1'b0, line_ack = 1'b0, clr_underrun = 1'b0;
  logic       hsync, vsync, display_on, frame_start, line_req, underrun;
  logic [9:0] hpos, vpos, line_num;
  logic [1:0] o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int         m_pix;
  bit         m_pend, m_under, m_blank, m_fs;
  int         m_num;
  req_state_t m_state;

  vga_line_scheduler #(
    .H_ACTIVE(TH_ACT), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_ACTIVE(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .hpos(hpos), .vpos(vpos), .frame_start(frame_start),
    .line_req(line_req), .line_num(line_num), .line_ack(line_ack),
    .underrun(underrun), .clr_underrun(clr_underrun), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int m_h();
    return m_pix % TH_TOT;
  endfunction

  function automatic int m_v();
    return m_pix / TH_TOT;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pix   = (TV_TOT - 1) * TH_TOT + TH_ACT;
    m_pend  = 0;
    m_under = 0;
    m_blank = 0;
    m_fs    = 0;
    m_num   = 0;
    m_state = REQ_IDLE;
  endfunction

  function automatic void model_step(input bit e, input bit a, input bit c);
    int h, v;
    bit wrap, req, miss;
    if (rst) begin
      model_reset();
      return;
    end
    h    = m_h();
    v    = m_v();
    wrap = e && (h == TH_TOT - 1);
    req  = e && (h == TH_ACT) && (((v + 1) % TV_TOT) < TV_ACT);
    miss = 0;
    m_fs = e && (m_pix == FRAME - 1);
    if (m_pend) begin
      if (a) begin
        m_pend = 0; m_state = REQ_DONE;
      end else if (wrap) begin
        m_pend = 0; m_state = REQ_MISS; miss = 1;
      end
    end else if (req) begin
      m_pend = 1; m_state = REQ_PEND; m_num = (v + 1) % TV_TOT;
    end
    if (miss)   m_under = 1;
    else if (c) m_under = 0;
`ifdef VGA_UNDERRUN_BLANK_EN
    if (wrap) m_blank = miss;
`endif
    if (e) m_pix = (m_pix + 1) % FRAME;
  endfunction

  function automatic void check_all();
    int h, v;
    h = m_h();
    v = m_v();
    check("hpos", 32'(hpos), 32'(h));
    check("vpos", 32'(vpos), 32'(v));
    check("hsync", 32'(hsync), 32'(!(h >= TH_ACT + TH_FP && h < TH_ACT + TH_FP + TH_SYNC)));
    check("vsync", 32'(vsync), 32'(!(v >= TV_ACT + TV_FP && v < TV_ACT + TV_FP + TV_SYNC)));
    check("display_on", 32'(display_on), 32'(h < TH_ACT && v < TV_ACT && !m_blank));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("line_req", 32'(line_req), 32'(m_pend));
    if (m_pend) check("line_num", 32'(line_num), 32'(m_num));
    check("underrun", 32'(underrun), 32'(m_under));
    check("state", 32'(o_dbg_state), 32'(m_state));
  endfunction

  function automatic void check_reset_vals(input string tag);
    check({tag, "_hpos"}, 32'(hpos), 32'(TH_ACT));
    check({tag, "_vpos"}, 32'(vpos), 32'(TV_TOT - 1));
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_display"}, 32'(display_on), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_req"}, 32'(line_req), 32'd0);
    check({tag, "_num"}, 32'(line_num), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_state"}, 32'(o_dbg_state), 32'(REQ_IDLE));
  endfunction

  task automatic cycle(input bit e, input bit a, input bit c);
    ena = e; line_ack = a; clr_underrun = c;
    @(posedge clk);
    model_step(e, a, c);
    @(negedge clk);
    check_all();
  endtask

  // Advance with ena=1 until the model beam sits at (tv, th); bounded by one frame.
  task automatic goto(input int tv, input int th, input bit auto_ack, input bit clr_v);
    int n = 0;
    while (!(m_h() == th && m_v() == tv) && n < FRAME + TH_TOT) begin
      cycle(1'b1, auto_ack && m_pend, clr_v);
      n++;
    end
    check("goto_reached", 32'(m_h() == th && m_v() == tv), 32'd1);
  endtask

  typedef struct {
    bit         ena, ack, clr;
    int         exp_h, exp_v;
    bit         exp_req;
    int         exp_num;
    bit         exp_under;
    req_state_t exp_state;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int hs_cnt, vs_cnt, fs_cnt, fs_first, fs_second, dl5, dl6;

    vecs[0] = '{1, 0, 0, TH_ACT + 1, TV_TOT - 1, 1, 0, 0, REQ_PEND};
    vecs[1] = '{1, 1, 0, TH_ACT + 2, TV_TOT - 1, 0, 0, 0, REQ_DONE};
    vecs[2] = '{0, 1, 0, TH_ACT + 2, TV_TOT - 1, 0, 0, 0, REQ_DONE};
    vecs[3] = '{1, 0, 1, TH_ACT + 3, TV_TOT - 1, 0, 0, 0, REQ_DONE};
    vecs[4] = '{0, 0, 0, TH_ACT + 3, TV_TOT - 1, 0, 0, 0, REQ_DONE};

    model_reset();
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].ena, vecs[i].ack, vecs[i].clr);
      check($sformatf("vec%0d_hpos", i), 32'(hpos), 32'(vecs[i].exp_h));
      check($sformatf("vec%0d_vpos", i), 32'(vpos), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_req", i), 32'(line_req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d_num", i), 32'(line_num), 32'(vecs[i].exp_num));
      check($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_under));
      check($sformatf("vec%0d_state", i), 32'(o_dbg_state), 32'(vecs[i].exp_state));
    end

    // first visible pixel at (0,0)
    goto(0, 0, 1'b1, 1'b0);
    check("first_display", 32'(display_on), 32'd1);
    check("first_frame_start", 32'(frame_start), 32'd1);

    // two frames with ack one cycle after every request
    hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_first = 0; fs_second = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      cycle(1'b1, m_pend, 1'b0);
      if (!hsync) hs_cnt++;
      if (!vsync) vs_cnt++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = i;
        if (fs_cnt == 2) fs_second = i;
      end
    end
    check("hsync_low_count", 32'(hs_cnt), 32'(2 * TV_TOT * TH_SYNC));
    check("vsync_low_count", 32'(vs_cnt), 32'(2 * TV_SYNC * TH_TOT));
    check("frame_start_count", 32'(fs_cnt), 32'd2);
    check("frame_start_first", 32'(fs_first), 32'(FRAME));
    check("frame_start_second", 32'(fs_second), 32'(2 * FRAME));
    check("two_frame_underrun", 32'(underrun), 32'd0);

    // randomized segments with varying ack eagerness, stray acks and clears
    for (int s = 0; s < 6; s++) begin
      int ack_div;
      ack_div = $urandom_range(0, 50);
      for (int i = 0; i < 1000; i++) begin
        bit e, a, c;
        e = ($urandom_range(0, 9) != 0);
        a = m_pend ? ($urandom_range(0, ack_div) == 0) : ($urandom_range(0, 7) == 0);
        c = ($urandom_range(0, 40) == 0);
        cycle(e, a, c);
      end
    end

    // ack coincident with the line wrap is accepted
    goto(9, TH_ACT, 1'b1, 1'b1);
    goto(9, TH_TOT - 1, 1'b0, 1'b0);
    check("wrap_ack_pending", 32'(line_req), 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    check("wrap_ack_state", 32'(o_dbg_state), 32'(REQ_DONE));
    check("wrap_ack_underrun", 32'(underrun), 32'd0);
    check("wrap_ack_hpos", 32'(hpos), 32'd0);

    // clear on the same edge as a new miss: set wins
    goto(10, TH_ACT, 1'b1, 1'b0);
    goto(10, TH_TOT - 1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check("set_wins_underrun", 32'(underrun), 32'd1);
    check("set_wins_state", 32'(o_dbg_state), 32'(REQ_MISS));
    check("set_wins_req", 32'(line_req), 32'd0);

    // withheld ack for line 5
    goto(4, TH_ACT, 1'b1, 1'b1);
    goto(4, TH_TOT - 1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("miss5_vpos", 32'(vpos), 32'd5);
    check("miss5_req", 32'(line_req), 32'd0);
    check("miss5_underrun", 32'(underrun), 32'd1);
    dl5 = 32'(display_on);
    dl6 = 0;
    for (int i = 1; i < 2 * TH_TOT; i++) begin
      cycle(1'b1, m_pend, 1'b0);
      if (vpos == 10'd5) dl5 += 32'(display_on);
      if (vpos == 10'd6) dl6 += 32'(display_on);
    end
`ifdef VGA_UNDERRUN_BLANK_EN
    check("line5_display_cycles", 32'(dl5), 32'd0);
`else
    check("line5_display_cycles", 32'(dl5), 32'(TH_ACT));
`endif
    check("line6_display_cycles", 32'(dl6), 32'(TH_ACT));

    // freeze with a request pending; the ack is still taken
    goto(12, TH_ACT, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    check("freeze_pending", 32'(line_req), 32'd1);
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, (i == 10), 1'b0);
      check("freeze_hpos", 32'(hpos), 32'(TH_ACT + 4));
      check("freeze_vpos", 32'(vpos), 32'd12);
    end
    check("freeze_ack_taken", 32'(o_dbg_state), 32'(REQ_DONE));
    cycle(1'b1, 1'b0, 1'b0);
    check("freeze_resume_hpos", 32'(hpos), 32'(TH_ACT + 5));

    // asynchronous reset mid-frame with a request pending
    goto(20, TH_ACT, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("prereset_pending", 32'(line_req), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    check_reset_vals("post_rst");
    cycle(1'b1, 1'b0, 1'b0);
    check("post_rst_req", 32'(line_req), 32'd1);
    check("post_rst_num", 32'(line_num), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
